load_store_align: RTL and testbench

- Sits between the pipeline MEM stage and the data port of the synchronous unified memory.
- Converts RV32I load/store requests (funct3, byte address, store data) into word-address accesses with a 4-bit byte-lane mask and lane-shifted write data.
- The memory returns read data one cycle after the read enable. This block registers the load metadata across that cycle, then extracts, aligns and sign/zero-extends the returned word.
- Detects misaligned and illegal accesses.

---
 rtl/load_store_align.sv | 191 +++++++++++++++++++
 tb/tb_load_store_align.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_align.sv
// RV32I load/store aligner between the MEM stage and a synchronous memory data port.
// Define LSA_MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into two beats.
module load_store_align #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPLIT2 = 2'd1, WAIT_HI = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              rsp_q, rsp_d;
  logic              fault_q, fault_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [ADDR_W-1:0] split_addr_q, split_addr_d;
  logic [3:0]        split_mask_q, split_mask_d;
  logic [XLEN-1:0]   split_wdata_q, split_wdata_d;
  logic              split_we_q, split_we_d;

  logic              split_en;
  logic [1:0]        off;
  logic              is_b, is_h, is_w, illegal, misal, split_need;
  logic              do_fault, do_split, accept, go;
  logic [3:0]        lane_mask, beat2_mask;
  logic [XLEN-1:0]   shifted_wdata, lane_wdata, beat2_wdata;
  logic [ADDR_W-1:0] word_addr, next_word_addr;

`ifdef LSA_MISALIGN_SPLIT_EN
  assign split_en = 1'b1;
`else
  assign split_en = 1'b0;
`endif

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{(XLEN-8){w[7]}}, w[7:0]};
      3'b001:  return {{(XLEN-16){w[15]}}, w[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, w[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Handshake: a request transfers on a cycle where req_valid & req_ready; only SPLIT2 drops ready.
  assign req_ready = (state_q != SPLIT2);
  assign accept    = req_valid & req_ready;

  always_comb begin
    off            = req_addr[1:0];
    is_b           = (req_funct3[1:0] == 2'b00);
    is_h           = (req_funct3[1:0] == 2'b01);
    is_w           = (req_funct3[1:0] == 2'b10);
    illegal        = (req_funct3[1:0] == 2'b11) | (req_we & req_funct3[2]) | (req_funct3 == 3'b110);
    misal          = (is_h & off[0]) | (is_w & (off != 2'b00));
    split_need     = split_en & ((is_h & (off == 2'b11)) | (is_w & (off != 2'b00)));
    do_fault       = illegal | (misal & ~split_en);
    do_split       = ~illegal & split_need;
    go             = accept & ~do_fault;
    word_addr      = {req_addr[ADDR_W-1:2], 2'b00};
    next_word_addr = {req_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
    shifted_wdata  = req_wdata << {off, 3'b000};

    // Shifting the lane pattern and truncating to 4 bits also yields the first-beat mask.
    if (is_b)      lane_mask = 4'b0001 << off;
    else if (is_h) lane_mask = 4'b0011 << off;
    else           lane_mask = 4'b1111 << off;

    if (is_b)                lane_wdata = {4{req_wdata[7:0]}};
    else if (is_h & ~off[0]) lane_wdata = {2{req_wdata[15:0]}};
    else                     lane_wdata = shifted_wdata;

    case (off)
      2'b01:   begin beat2_mask = 4'b0001;                 beat2_wdata = req_wdata >> 24; end
      2'b10:   begin beat2_mask = 4'b0011;                 beat2_wdata = req_wdata >> 16; end
      2'b11:   begin beat2_mask = is_h ? 4'b0001 : 4'b0111; beat2_wdata = req_wdata >> 8;  end
      default: begin beat2_mask = 4'b0000;                 beat2_wdata = '0;              end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_addr      = '0;
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_mask      = 4'b0000;
    mem_wdata     = '0;
    lo_d          = lo_q;
    split_addr_d  = split_addr_q;
    split_mask_d  = split_mask_q;
    split_wdata_d = split_wdata_q;
    split_we_d    = split_we_q;
    case (state_q)
      SPLIT2: begin
        mem_addr  = split_addr_q;
        mem_ren   = ~split_we_q;
        mem_wen   = split_we_q;
        mem_mask  = split_mask_q;
        mem_wdata = split_we_q ? split_wdata_q : '0;
        // Beat-1 read data is on mem_rdata now; keep its upper lanes right-justified.
        if (!split_we_q) lo_d = mem_rdata >> {off_q, 3'b000};
        state_d   = split_we_q ? IDLE : WAIT_HI;
      end
      default: begin
        state_d = IDLE;
        if (go) begin
          mem_addr  = word_addr;
          mem_ren   = ~req_we;
          mem_wen   = req_we;
          mem_mask  = lane_mask;
          mem_wdata = req_we ? lane_wdata : '0;
          if (do_split) begin
            state_d       = SPLIT2;
            split_addr_d  = next_word_addr;
            split_mask_d  = beat2_mask;
            split_wdata_d = beat2_wdata;
            split_we_d    = req_we;
          end
        end
      end
    endcase
  end

  always_comb begin
    rsp_d   = go & ~req_we & ~do_split;
    fault_d = accept & do_fault;
    off_d   = off_q;
    f3_d    = f3_q;
    if (go & ~req_we) begin
      off_d = off;
      f3_d  = req_funct3;
    end
  end

  // Load metadata is registered; the returned word is extracted in the cycle it arrives.
  assign resp_valid = rsp_q | (state_q == WAIT_HI);
  assign fault      = fault_q;

  always_comb begin
    resp_rdata = '0;
    if (state_q == WAIT_HI)
      resp_rdata = extend(lo_q | (mem_rdata << {(3'd4 - {1'b0, off_q}), 3'b000}), f3_q);
    else if (rsp_q)
      resp_rdata = extend(mem_rdata >> {off_q, 3'b000}, f3_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rsp_q         <= 1'b0;
      fault_q       <= 1'b0;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      lo_q          <= '0;
      split_addr_q  <= '0;
      split_mask_q  <= 4'b0000;
      split_wdata_q <= '0;
      split_we_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_q         <= rsp_d;
      fault_q       <= fault_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      lo_q          <= lo_d;
      split_addr_q  <= split_addr_d;
      split_mask_q  <= split_mask_d;
      split_wdata_q <= split_wdata_d;
      split_we_q    <= split_we_d;
    end
  end

endmodule

// File: tb/tb_load_store_align.sv
// Directed and randomized checks of load_store_align against a byte-addressed memory model.
module tb_load_store_align;
  logic        clk;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic [3:0]  mem_mask;
  logic        resp_valid, fault;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  logic [7:0]  ref_bytes [256];
  logic [31:0] exp_q[$];
  int          exp_t_q[$];
  int          flt_t_q[$];
  int          cyc;
  logic        have, ev, ef;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_d;
  logic [2:0]  ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  load_store_align #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Synchronous memory: read data one cycle after mem_ren, old data on same-cycle write.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_ren) mem_rdata <= mem[mem_addr[7:2]];
    if (mem_wen) mem[mem_addr[7:2]] <= merge(mem[mem_addr[7:2]], mem_wdata, mem_mask);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    next_cycle();
    pl_en = 1'b1; pl_idx = 6'(idx); pl_val = v;
    next_cycle();
    pl_en = 1'b0;
  endtask

  // Reference load: gather bytes from the byte memory, then extend by funct3.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int          sz;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    v  = 32'd0;
    for (int b = 0; b < sz; b++) v = v | (32'(ref_bytes[(a + 32'(b)) & 32'hFF]) << (8 * b));
    if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic check_due();
    ev = (exp_t_q.size() > 0) && (exp_t_q[0] == cyc);
    chk("rnd_resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) begin
      chk("rnd_resp_rdata", resp_rdata, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_t_q.pop_front());
    end
    ef = (flt_t_q.size() > 0) && (flt_t_q[0] == cyc);
    chk("rnd_fault", 32'(fault), 32'(ef));
    if (ef) void'(flt_t_q.pop_front());
  endtask

  task automatic model_accept();
    int  sz, off;
    logic ill, mis;
    sz  = (r_f3[1:0] == 2'd0) ? 1 : (r_f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(r_a[1:0]);
    ill = (r_f3[1:0] == 2'd3) || (r_we && r_f3[2]) || (r_f3 == 3'd6);
`ifdef LSA_MISALIGN_SPLIT_EN
    mis = 1'b0;
`else
    mis = (off % sz) != 0;
`endif
    if (ill || mis) begin
      flt_t_q.push_back(cyc + 1);
      chk("rnd_no_access", {30'd0, mem_ren, mem_wen}, 32'd0);
    end else begin
      chk("rnd_addr", mem_addr, r_a & ~32'd3);
      chk("rnd_enables", {30'd0, mem_ren, mem_wen}, r_we ? 32'd1 : 32'd2);
      if (r_we) begin
        for (int b = 0; b < sz; b++) ref_bytes[(r_a + 32'(b)) & 32'hFF] = r_d[8*b +: 8];
      end else begin
        exp_q.push_back(ref_load(r_f3, r_a));
        exp_t_q.push_back(cyc + ((off + sz > 4) ? 2 : 1));
      end
    end
  endtask

  initial begin
    idle_in();
    pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #6;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    preload(0, 32'd0);
    next_cycle(); rst_n = 1'b1;

    // SB into lane 2
    next_cycle(); drive(1'b1, 3'b000, 32'h102, 32'h000000A5); mid();
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_mask", 32'(mem_mask), 32'h4);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_wen", 32'(mem_wen), 32'd1);
    chk("sb_ren", 32'(mem_ren), 32'd0);
    next_cycle(); idle_in(); mid();
    chk("sb_wen_once", 32'(mem_wen), 32'd0);
    chk("sb_no_resp", 32'(resp_valid), 32'd0);
    chk("sb_mem_word", mem[0], 32'h00A50000);

    // LB then LBU back to back from lane 3
    preload(0, 32'h80FF1234);
    next_cycle(); drive(1'b0, 3'b000, 32'h103, 32'd0); mid();
    chk("lb_ren", 32'(mem_ren), 32'd1);
    chk("lb_addr", mem_addr, 32'h100);
    next_cycle(); drive(1'b0, 3'b100, 32'h103, 32'd0); mid();
    chk("lb_valid", 32'(resp_valid), 32'd1);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
    next_cycle(); idle_in(); mid();
    chk("lbu_valid", 32'(resp_valid), 32'd1);
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    next_cycle(); mid();
    chk("lbu_valid_once", 32'(resp_valid), 32'd0);

    // LH then LW on consecutive cycles
    preload(0, 32'hBEEF0000);
    preload(1, 32'h11223344);
    next_cycle(); drive(1'b0, 3'b001, 32'h102, 32'd0);
    next_cycle(); drive(1'b0, 3'b010, 32'h104, 32'd0); mid();
    chk("lh_rdata", resp_rdata, 32'hFFFFBEEF);
    chk("lw_addr", mem_addr, 32'h104);
    next_cycle(); idle_in(); mid();
    chk("lw_valid", 32'(resp_valid), 32'd1);
    chk("lw_rdata", resp_rdata, 32'h11223344);

`ifndef LSA_MISALIGN_SPLIT_EN
    // Misaligned word load faults
    next_cycle(); drive(1'b0, 3'b010, 32'h101, 32'd0); mid();
    chk("mis_no_ren", 32'(mem_ren), 32'd0);
    chk("mis_ready", 32'(req_ready), 32'd1);
    next_cycle(); idle_in(); mid();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_no_resp", 32'(resp_valid), 32'd0);
    chk("mis_ready2", 32'(req_ready), 32'd1);
    next_cycle(); mid();
    chk("mis_fault_once", 32'(fault), 32'd0);
`endif

    // Illegal store funct3
    next_cycle(); drive(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF); mid();
    chk("ill_no_wen", 32'(mem_wen), 32'd0);
    next_cycle(); idle_in(); mid();
    chk("ill_fault", 32'(fault), 32'd1);

    // Store right after a load to the same word: load sees old data
    preload(2, 32'h12345678);
    next_cycle(); drive(1'b0, 3'b010, 32'h108, 32'd0);
    next_cycle(); drive(1'b1, 3'b010, 32'h108, 32'hCAFEF00D); mid();
    chk("ldst_valid", 32'(resp_valid), 32'd1);
    chk("ldst_old", resp_rdata, 32'h12345678);
    next_cycle(); drive(1'b0, 3'b010, 32'h108, 32'd0);
    next_cycle(); idle_in(); mid();
    chk("ldst_new", resp_rdata, 32'hCAFEF00D);

    // Reset while a load response is pending
    next_cycle(); drive(1'b0, 3'b010, 32'h100, 32'd0);
    next_cycle(); idle_in(); rst_n = 1'b0; #1;
    chk("rstmid_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_rdata", resp_rdata, 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    next_cycle(); rst_n = 1'b1; mid();
    chk("rstmid_no_resp", 32'(resp_valid), 32'd0);

`ifdef LSA_MISALIGN_SPLIT_EN
    // Split load
    preload(0, 32'hAABB0000);
    preload(1, 32'h0000CCDD);
    next_cycle(); drive(1'b0, 3'b010, 32'h102, 32'd0); mid();
    chk("spl_ld_addr1", mem_addr, 32'h100);
    chk("spl_ld_ren1", 32'(mem_ren), 32'd1);
    next_cycle(); idle_in(); mid();
    chk("spl_ld_addr2", mem_addr, 32'h104);
    chk("spl_ld_ren2", 32'(mem_ren), 32'd1);
    chk("spl_ld_ready", 32'(req_ready), 32'd0);
    chk("spl_ld_early", 32'(resp_valid), 32'd0);
    next_cycle(); mid();
    chk("spl_ld_valid", 32'(resp_valid), 32'd1);
    chk("spl_ld_rdata", resp_rdata, 32'hCCDDAABB);
    chk("spl_ld_ready2", 32'(req_ready), 32'd1);

    // Split store
    preload(0, 32'd0);
    preload(1, 32'd0);
    next_cycle(); drive(1'b1, 3'b010, 32'h103, 32'h44332211); mid();
    chk("spl_st_mask1", 32'(mem_mask), 32'h8);
    chk("spl_st_wdata1", mem_wdata & 32'hFF000000, 32'h11000000);
    next_cycle(); idle_in(); mid();
    chk("spl_st_addr2", mem_addr, 32'h104);
    chk("spl_st_mask2", 32'(mem_mask), 32'h7);
    chk("spl_st_wdata2", mem_wdata & 32'h00FFFFFF, 32'h00443322);
    next_cycle(); mid();
    chk("spl_st_w0", mem[0], 32'h11000000);
    chk("spl_st_w1", mem[1], 32'h00443322);

    // Reset in SPLIT2 drops the second beat
    next_cycle(); drive(1'b1, 3'b010, 32'h103, 32'hAAAAAAAA);
    next_cycle(); idle_in(); rst_n = 1'b0; #1;
    chk("spl_rst_wen", 32'(mem_wen), 32'd0);
    chk("spl_rst_ready", 32'(req_ready), 32'd1);
    next_cycle(); rst_n = 1'b1;
    next_cycle(); drive(1'b0, 3'b010, 32'h104, 32'd0);
    next_cycle(); idle_in(); mid();
    chk("spl_rst_no_beat2", resp_rdata, 32'h00443322);
`endif

    // Randomized phase against the byte-memory reference
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      preload(i, v);
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = v[8*b +: 8];
    end
    have = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 600; k++) begin
      next_cycle();
      cyc++;
      if (!have) begin
        if ($urandom_range(0, 3) != 0) begin
          r_we = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
          else if (r_we)                 r_f3 = 3'($urandom_range(0, 2));
          else                           r_f3 = ld_ok[$urandom_range(0, 4)];
          r_a  = 32'h100 + 32'($urandom_range(0, 247));
          r_d  = $urandom;
          have = 1'b1;
          drive(r_we, r_f3, r_a, r_d);
        end else begin
          idle_in();
        end
      end
      mid();
      check_due();
      if (have && req_ready) begin
        model_accept();
        have = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      idle_in();
      cyc++;
      mid();
      check_due();
    end
    chk("rnd_queues_drained", 32'(exp_q.size() + flt_t_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
